// File: rtl/serialize_10b.sv
// 10-bit parallel-to-serial line stage that sits behind encode_8b10b and sends bit "a" (d_in[9]) first.
// Defining SERIALIZE_SYNC_PREAMBLE_EN adds a K28.5 comma preamble before the data words.
//
// state    | meaning
// ---------|------------------------------------------------------------
// ST_RESET | idle after reset; the first enabled cycle loads word 0
// ST_SYNC  | sending comma preamble words, alternating RD- and RD+
// ST_DATA  | every word boundary loads d_in from the encoder
module serialize_10b #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_WORDS   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] d_in,
    output logic       nextword_enable,
    output logic       d_out,
    output logic       sync_done
);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 1 || SYNC_WORDS < 2 || (SYNC_WORDS % 2) != 0) begin : g_param_check
        $error("serialize_10b: CLKS_PER_BIT must be >=1 and SYNC_WORDS even and >=2");
    end

`ifdef SERIALIZE_SYNC_PREAMBLE_EN
    typedef enum logic [1:0] {ST_RESET, ST_SYNC, ST_DATA} state_t;
    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam int PRE_W = $clog2(SYNC_WORDS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SYNC_WORDS);
    logic [PRE_W-1:0] pre_cnt, pre_cnt_nx;
`else
    typedef enum logic {ST_RESET, ST_DATA} state_t;
`endif

    state_t           state, state_nx;
    logic [9:0]       sr, load_word;
    logic [3:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             tick, word_end, bit8_end, data_set;

    assign tick     = enable && (div_cnt == DIV_MAX);
    assign word_end = tick && (bit_cnt == 4'd9);
    // The request lands on the last cycle of bit 8 so d_in settles a full bit before the load.
    assign bit8_end = !rst && tick && (bit_cnt == 4'd8);

    always_comb begin
        state_nx        = state;
        load_word       = d_in;
        data_set        = 1'b0;
        nextword_enable = 1'b0;
`ifdef SERIALIZE_SYNC_PREAMBLE_EN
        pre_cnt_nx      = pre_cnt;
`endif
        case (state)
            ST_RESET: begin
                if (word_end) begin
`ifdef SERIALIZE_SYNC_PREAMBLE_EN
                    state_nx   = ST_SYNC;
                    load_word  = K28_5_NEG;
                    pre_cnt_nx = PRE_W'(1);
`else
                    state_nx   = ST_DATA;
                    data_set   = 1'b1;
`endif
                end
            end
`ifdef SERIALIZE_SYNC_PREAMBLE_EN
            ST_SYNC: begin
                // pre_cnt counts preamble words already loaded; at PRE_LAST the final comma is on the line.
                nextword_enable = bit8_end && (pre_cnt == PRE_LAST);
                if (word_end) begin
                    if (pre_cnt == PRE_LAST) begin
                        state_nx = ST_DATA;
                        data_set = 1'b1;
                    end else begin
                        load_word  = pre_cnt[0] ? K28_5_POS : K28_5_NEG;
                        pre_cnt_nx = pre_cnt + 1'b1;
                    end
                end
            end
`endif
            ST_DATA: begin
                nextword_enable = bit8_end;
            end
            default: begin
                state_nx = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RESET;
`ifdef SERIALIZE_SYNC_PREAMBLE_EN
            pre_cnt <= '0;
`endif
        end else begin
            state <= state_nx;
`ifdef SERIALIZE_SYNC_PREAMBLE_EN
            pre_cnt <= pre_cnt_nx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            bit_cnt   <= 4'd9;
            div_cnt   <= DIV_MAX;
            d_out     <= 1'b0;
            sync_done <= 1'b0;
        end else begin
            if (enable) begin
                d_out   <= sr[9];
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end
            if (tick) begin
                if (bit_cnt == 4'd9) begin
                    sr      <= load_word;
                    bit_cnt <= 4'd0;
                end else begin
                    sr      <= {sr[8:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
            if (data_set) begin
                sync_done <= 1'b1;
            end
        end
    end
endmodule

// File: doc/serialize_10b.md
# serialize_10b

Parallel-to-serial stage directly downstream of `encode_8b10b`. It loads one 10-bit code group at a time from the encoder, shifts it onto the single-bit line driver one bit per bit period, and generates the encoder's `nextword_enable` request so the next code group is ready exactly at the word boundary. After reset it optionally transmits a K28.5 comma preamble so the receiver's word aligner can lock before data starts.

## Interface
- `CLKS_PER_BIT`, 1: clock cycles per transmitted bit; integer ≥1.
- `SYNC_WORDS`, 16: number of K28.5 preamble words after reset; even, ≥2. Used only with `SERIALIZE_SYNC_PREAMBLE_EN`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: high = line running; low = freeze all counters and hold `d_out`.
- `d_in` input 10: code group from the encoder, `d_in[9]` = bit "a" (transmitted first), `d_in[0]` = bit "j".
- `nextword_enable` output 1: one-clock request pulse to the encoder to present the next code group.
- `d_out` output 1: serial line bit, registered.
- `sync_done` output 1: high once the first data word has been loaded; stays high until reset.

## Operation
- Datapath: 10-bit shift register `sr`, bit index `bit_cnt` (0..9), clock-divider `div_cnt` (0..CLKS_PER_BIT-1). `d_out` is a register following `sr[9]`.
- Bit tick: asserted on a cycle where `enable`=1 and `div_cnt`=CLKS_PER_BIT-1; `div_cnt` wraps to 0 on tick, else increments while `enable`=1.
- On each tick: if `bit_cnt`=9, load a new word into `sr` and set `bit_cnt`=0; otherwise shift `sr` left by one (zero fill) and increment `bit_cnt`.
- `nextword_enable`=1 for exactly the one clock cycle that is the last cycle of bit index 8 (`bit_cnt`=8, `div_cnt`=CLKS_PER_BIT-1, `enable`=1), in DATA state and in the final preamble word only. Encoder updates `d_in` at that edge; serializer loads `d_in` at the end of bit 9.
- States:
  - RESET: entered while `rst`=1. First cycle with `rst`=0 and `enable`=1 performs the initial load (preamble word 0 or `d_in`) and moves to SYNC (macro on) or DATA (macro off).
  - SYNC: word sources alternate K28.5 RD− `0011111010` and RD+ `1100000101`, starting RD−. Preamble word counter counts loads; after SYNC_WORDS words, the next load takes `d_in`, enters DATA, sets `sync_done`. Ending on an RD+ word leaves line disparity negative, matching the encoder's reset disparity.
  - DATA: every load takes `d_in`. Stays until reset.
- `rst` overrides `enable`. Reset mid-word abandons the word; the line restarts from RESET.
- `enable` low mid-bit: `div_cnt`, `bit_cnt`, `sr`, `d_out` all hold; no pulse generated; resumes exactly where stopped.

## Timing
- Reset values: `d_out`=0, `nextword_enable`=0, `sync_done`=0, `sr`=0, `bit_cnt`=9, `div_cnt`=CLKS_PER_BIT-1 (so the first enabled cycle is a load tick).
- Load edge E0: `sr` loaded; `d_out` shows word bit 9 from edge E0+1. Each bit is held exactly CLKS_PER_BIT cycles (with `enable` continuously high). Word period = 10×CLKS_PER_BIT cycles.
- `d_out` lags `sr[9]` by one clock; constant pipeline latency, 1 cycle from load to first bit.
- `nextword_enable` pulse ends at the edge CLKS_PER_BIT cycles before the next load edge.
- `sync_done` rises at the load edge of the first data word.

## Configuration
- `SERIALIZE_SYNC_PREAMBLE_EN` defined: SYNC state, preamble counter and comma constants compiled in; SYNC_WORDS comma words precede data; first `nextword_enable` pulse occurs in the last preamble word.
- Undefined: no SYNC state; RESET goes straight to DATA; the first load takes `d_in` as presented at E0; `nextword_enable` pulses in every word from the first; `sync_done` rises at E0.

## Test plan
- Reset/idle: hold `rst`=1 for 5 cycles with `enable`=1 -> `d_out`=0, `nextword_enable`=0, `sync_done`=0 throughout.
- Preamble (macro on, SYNC_WORDS=4, CLKS_PER_BIT=1): release reset -> 40 line bits equal to `0011111010 1100000101` repeated twice; exactly one `nextword_enable` pulse, at bit 8 of word 3; `sync_done` rises at load of word 4.
- Data (macro off, CLKS_PER_BIT=1): bench model returns incrementing encoder words 0x155, 0x2AA, 0x3F0 on each pulse -> line carries those words MSB first, pulse period exactly 10 cycles, pulse at bit index 8.
- Divider (CLKS_PER_BIT=4): each bit held 4 cycles, word period 40 cycles, pulse width 1 cycle in last cycle of bit 8.
- Enable stall: drop `enable` for 7 cycles mid-bit 5 -> `d_out` frozen, no pulse, remaining bits and next pulse shifted by exactly 7 cycles.
- Reset mid-word: assert `rst` for 1 cycle during bit 3 of a data word -> outputs return to reset values next edge; sequence restarts from preamble word 0 (macro on).
